// File: rtl/parallel_to_serial.sv
// Word-to-bitstream serializer, LSB first, with a one-word holding register
// so the next word can be accepted while the current one is shifting out.
module parallel_to_serial #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             parallel_valid,
  input  logic [width-1:0] parallel_data,
  output logic             parallel_ready,
  output logic             serial_valid,
  output logic             serial_data,
  output logic             serial_last,
  output logic             busy
);

  localparam int CW = $clog2(width);
  localparam logic [CW-1:0] LAST = CW'(width - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [width-1:0] shreg_q, shreg_d;
  logic [width-1:0] holdData_q, holdData_d;
  logic             holdValid_q, holdValid_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             handshake;
  logic             loadPoint;

  assign parallel_ready = !holdValid_q;
  assign handshake      = parallel_valid && parallel_ready;
  assign loadPoint      = (state_q == IDLE) || (cnt_q == LAST);

  // At the load point a held word always wins over a fresh one; a word that
  // arrives while the shifter is still busy is parked in the holding register.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    holdData_d  = holdData_q;
    holdValid_d = holdValid_q;
    if (!loadPoint) begin
      shreg_d = shreg_q >> 1;
      cnt_d   = cnt_q + CW'(1);
      if (handshake) begin
        holdData_d  = parallel_data;
        holdValid_d = 1'b1;
      end
    end else if (holdValid_q) begin
      shreg_d     = holdData_q;
      holdValid_d = 1'b0;
      cnt_d       = '0;
      state_d     = SHIFT;
    end else if (handshake) begin
      shreg_d = parallel_data;
      cnt_d   = '0;
      state_d = SHIFT;
    end else begin
      cnt_d   = '0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      holdData_q  <= '0;
      holdValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      holdData_q  <= holdData_d;
      holdValid_q <= holdValid_d;
    end
  end

  assign serial_valid = (state_q == SHIFT);
  assign serial_data  = serial_valid && shreg_q[0];
  assign serial_last  = serial_valid && (cnt_q == LAST);
  assign busy         = serial_valid || holdValid_q;

endmodule
